// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - core/dma arbiter for the shared memory port with timeout watchdog

module mem_port_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic          clk,
  input  logic          reset,

  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_adr,
  input  logic [DW-1:0] c_wd,
  output logic [DW-1:0] c_rd,
  output logic          c_done,

  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_adr,
  input  logic [DW-1:0] d_wd,
  output logic [DW-1:0] d_rd,
  output logic          d_done,

  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_adr,
  output logic [DW-1:0] m_wd,
  input  logic [DW-1:0] m_rd,
  input  logic          m_ack,

  output logic          busy,
  output logic          owner,
  output logic          timeout_err
);

  // Counter is at least one bit wide so MAX_WAIT=0 still elaborates cleanly.
  localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_LIM  = CW'(MAX_WAIT);
  localparam bit            TO_EN    = (MAX_WAIT != 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_C = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;

  // A master whose done pulse is high this cycle is still holding its old
  // request; masking it keeps the completed access from being re-granted.
  logic c_ok;
  logic d_ok;
  logic pick_c;
  logic pick_d;
  logic timed_out;

  assign c_ok   = c_req & ~c_done;
  assign d_ok   = d_req & ~d_done;
  // On a tie the master that did not own the port last time wins.
  assign pick_d = d_ok & (~c_ok | ~owner);
  assign pick_c = c_ok & ~pick_d;

  assign timed_out = TO_EN && (wait_cnt == CNT_LIM);

  // Arbitration FSM with registered memory-side and master-side outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      m_req       <= 1'b0;
      m_we        <= 1'b0;
      m_adr       <= '0;
      m_wd        <= '0;
      c_rd        <= '0;
      d_rd        <= '0;
      c_done      <= 1'b0;
      d_done      <= 1'b0;
      busy        <= 1'b0;
      owner       <= 1'b1;
      timeout_err <= 1'b0;
    end else begin
      c_done <= 1'b0;
      d_done <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_c) begin
            state    <= GRANT_C;
            m_req    <= 1'b1;
            m_we     <= c_we;
            m_adr    <= c_adr;
            m_wd     <= c_wd;
            busy     <= 1'b1;
            owner    <= 1'b0;
            wait_cnt <= '0;
          end else if (pick_d) begin
            state    <= GRANT_D;
            m_req    <= 1'b1;
            m_we     <= d_we;
            m_adr    <= d_adr;
            m_wd     <= d_wd;
            busy     <= 1'b1;
            owner    <= 1'b1;
            wait_cnt <= '0;
          end
        end

        GRANT_C, GRANT_D: begin
          if (m_ack || timed_out) begin
            // Ack takes priority over a timeout landing in the same cycle.
            state <= IDLE;
            m_req <= 1'b0;
            busy  <= 1'b0;
            if (!m_ack) begin
              timeout_err <= 1'b1;
            end
            if (state == GRANT_C) begin
              c_done <= 1'b1;
              c_rd   <= (m_ack && !m_we) ? m_rd : '0;
            end else begin
              d_done <= 1'b1;
              d_rd   <= (m_ack && !m_we) ? m_rd : '0;
            end
          end else if (wait_cnt != CNT_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          m_req <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter

module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          c_req, c_we, d_req, d_we, m_ack;
  logic [AW-1:0] c_adr, d_adr;
  logic [DW-1:0] c_wd, d_wd, m_rd;
  logic [DW-1:0] c_rd, d_rd, m_wd;
  logic [AW-1:0] m_adr;
  logic          c_done, d_done, m_req, m_we, busy, owner, timeout_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_adr(c_adr), .c_wd(c_wd), .c_rd(c_rd), .c_done(c_done),
    .d_req(d_req), .d_we(d_we), .d_adr(d_adr), .d_wd(d_wd), .d_rd(d_rd), .d_done(d_done),
    .m_req(m_req), .m_we(m_we), .m_adr(m_adr), .m_wd(m_wd), .m_rd(m_rd), .m_ack(m_ack),
    .busy(busy), .owner(owner), .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    c_req = 0; c_we = 0; c_adr = '0; c_wd = '0;
    d_req = 0; d_we = 0; d_adr = '0; d_wd = '0;
    m_ack = 0; m_rd = '0;
    tick();
    do_reset();

    // reset state
    chk("rst_m_req", m_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 1);
    chk("rst_terr", timeout_err, 0);
    chk("rst_m_adr", m_adr, 0);
    chk("rst_c_rd", c_rd, 0);

    // core read with immediate ack
    c_req = 1; c_adr = 32'h100;
    tick();
    chk("t1_m_req", m_req, 1);
    chk("t1_m_adr", m_adr, 32'h100);
    chk("t1_m_we", m_we, 0);
    chk("t1_busy", busy, 1);
    m_ack = 1; m_rd = 32'hDEADBEEF;
    tick();
    m_ack = 0;
    chk("t1_c_done", c_done, 1);
    chk("t1_c_rd", c_rd, 32'hDEADBEEF);
    chk("t1_busy_off", busy, 0);
    chk("t1_owner", owner, 0);
    c_req = 0;
    tick();
    chk("t1_done_pulse", c_done, 0);

    // round robin with both masters requesting continuously
    do_reset();
    c_req = 1; c_we = 0; c_adr = 32'h10;
    d_req = 1; d_we = 0; d_adr = 32'h20;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_m_req", m_req, 1);
      chk("rr_m_adr", m_adr, (i % 2 == 0) ? 32'h10 : 32'h20);
      chk("rr_owner", owner, i % 2);
      m_ack = 1; m_rd = 32'hA000 + i;
      tick();
      m_ack = 0;
      chk("rr_c_done", c_done, (i % 2 == 0) ? 1 : 0);
      chk("rr_d_done", d_done, (i % 2 == 1) ? 1 : 0);
      if (i % 2 == 0) chk("rr_c_rd", c_rd, 32'hA000 + i);
      else            chk("rr_d_rd", d_rd, 32'hA000 + i);
    end
    c_req = 0; d_req = 0;
    tick();

    // dma write, address change after grant, ack after 3 wait cycles
    d_req = 1; d_we = 1; d_adr = 32'h40; d_wd = 32'h12345678;
    tick();
    chk("t3_m_adr", m_adr, 32'h40);
    chk("t3_m_we", m_we, 1);
    chk("t3_m_wd", m_wd, 32'h12345678);
    d_adr = 32'h80; d_wd = 32'h0; d_we = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t3_hold_adr", m_adr, 32'h40);
      chk("t3_hold_we", m_we, 1);
      chk("t3_no_done", d_done, 0);
    end
    m_ack = 1; m_rd = 32'hFFFFFFFF;
    tick();
    m_ack = 0;
    chk("t3_d_done", d_done, 1);
    chk("t3_d_rd", d_rd, 0);
    d_req = 0;
    tick();

    // timeout abort after MAX_WAIT waiting cycles
    c_req = 1; c_we = 0; c_adr = 32'h200; m_rd = 32'hAAAA5555;
    tick();
    for (int k = 0; k < 4; k++) tick();
    chk("t4_still_req", m_req, 1);
    chk("t4_no_done_yet", c_done, 0);
    tick();
    chk("t4_c_done", c_done, 1);
    chk("t4_c_rd", c_rd, 0);
    chk("t4_terr", timeout_err, 1);
    chk("t4_m_req_off", m_req, 0);
    c_req = 0;
    tick();
    c_req = 1; c_adr = 32'h300;
    tick();
    chk("t4b_m_adr", m_adr, 32'h300);
    m_ack = 1; m_rd = 32'h55;
    tick();
    m_ack = 0;
    chk("t4b_c_done", c_done, 1);
    chk("t4b_c_rd", c_rd, 32'h55);
    chk("t4b_terr_sticky", timeout_err, 1);
    c_req = 0;
    tick();

    // ack arriving in the cycle the counter reaches MAX_WAIT
    do_reset();
    chk("t5_terr_cleared", timeout_err, 0);
    c_req = 1; c_adr = 32'h400;
    tick();
    for (int k = 0; k < 4; k++) tick();
    m_ack = 1; m_rd = 32'hCAFEF00D;
    tick();
    m_ack = 0;
    chk("t5_c_done", c_done, 1);
    chk("t5_c_rd", c_rd, 32'hCAFEF00D);
    chk("t5_terr", timeout_err, 0);
    c_req = 0;
    tick();

    // reset in the middle of a dma grant
    d_req = 1; d_we = 0; d_adr = 32'h60;
    tick();
    chk("t6_m_req", m_req, 1);
    chk("t6_owner_d", owner, 1);
    reset = 1;
    tick();
    reset = 0;
    chk("t6_m_req_off", m_req, 0);
    chk("t6_busy_off", busy, 0);
    chk("t6_owner", owner, 1);
    chk("t6_no_done", d_done, 0);
    d_req = 0; m_ack = 1; m_rd = 32'h777;
    tick();
    m_ack = 0;
    chk("t6_ack_ignored_done", d_done, 0);
    chk("t6_ack_ignored_rd", d_rd, 0);
    chk("t6_idle_req", m_req, 0);
    c_req = 1; c_we = 1; c_adr = 32'h44; c_wd = 32'h99;
    tick();
    chk("t6_c_m_req", m_req, 1);
    chk("t6_c_m_adr", m_adr, 32'h44);
    chk("t6_c_m_wd", m_wd, 32'h99);
    chk("t6_c_m_we", m_we, 1);
    m_ack = 1; m_rd = 32'h1234;
    tick();
    m_ack = 0;
    chk("t6_c_done", c_done, 1);
    chk("t6_c_rd", c_rd, 0);
    c_req = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbitrates the single unified instruction/data memory port between the multicycle core's memory interface (core side) and a loader/DMA master (dma side). Grants one access at a time and captures the address, write enable and write data at grant. Drives a variable-latency req/ack memory handshake and returns read data with a one-cycle done pulse. Includes a timeout watchdog so that a stuck memory cannot hang either master.

Parameters:
AW, 32, address width
DW, 32, data width
MAX_WAIT, 15, grant cycles without m_ack before the access is aborted; 0 disables the timeout

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
c_req  in  1  core access request, level, held until c_done
c_we  in  1  core write enable (1 = write)
c_adr  in  AW  core address
c_wd  in  DW  core write data
c_rd  out  DW  core read data, valid while c_done=1
c_done  out  1  core access complete, one-cycle pulse
d_req  in  1  dma access request, level, held until d_done
d_we  in  1  dma write enable
d_adr  in  AW  dma address
d_wd  in  DW  dma write data
d_rd  out  DW  dma read data, valid while d_done=1
d_done  out  1  dma access complete, one-cycle pulse
m_req  out  1  memory request, registered
m_we  out  1  memory write enable, registered
m_adr  out  AW  memory address, registered
m_wd  out  DW  memory write data, registered
m_rd  in  DW  memory read data, sampled when m_ack=1
m_ack  in  1  memory acknowledge, one cycle
busy  out  1  1 while in a grant state
owner  out  1  last/current grantee: 0 = core, 1 = dma
timeout_err  out  1  sticky abort flag

Behaviour:
- The clock is clk. Reset is synchronous and active-high on reset; the block has one clock.
- On reset, on the next edge:
  - state=IDLE.
  - m_req, m_we, c_done, d_done, busy, timeout_err = 0.
  - m_adr, m_wd, c_rd, d_rd = 0.
  - owner=1, so the core wins the first tie.
  - Wait counter = 0.
- States:
  - IDLE: arbitrate.
  - GRANT_C / GRANT_D: an access is outstanding for that master.
- Arbitration in IDLE, evaluated each cycle:
  - A requester whose done output is high in that same cycle is masked. This prevents re-granting a request that has just completed.
  - If exactly one unmasked request is present, grant it.
  - If both are present, grant the master that is not equal to owner (round-robin).
  - If none, stay in IDLE.
- On the grant edge:
  - Enter GRANT_x.
  - Register m_adr/m_we/m_wd from the granted master's inputs.
  - Set m_req=1, busy=1, owner=x, counter=0.
  - Later changes on the master's inputs have no effect until its done.
- In GRANT_x, m_ack=1 sampled:
  - Next edge: IDLE, m_req=0, busy=0, x_done=1 for exactly one cycle.
  - For a read, x_rd=m_rd. For a write, x_rd=0.
- In GRANT_x, m_ack=0:
  - Counter increments.
  - If MAX_WAIT!=0 and the counter has reached MAX_WAIT, the access is aborted on the next edge: IDLE, m_req=0, x_done=1, x_rd=0, timeout_err=1.
- Simultaneous m_ack and timeout in the same cycle: the ack wins, giving normal completion with no error.
- timeout_err is cleared only by reset.
- Counter width is clog2(MAX_WAIT+1); the counter saturates and never wraps.
- m_ack outside a grant state is ignored.
- Latency:
  - Request seen in IDLE at cycle N gives m_req in N+1.
  - Ack at cycle N+1+k gives done at N+2+k.
  - Minimum per-access period is 3 cycles.
- c_done and d_done are never high in the same cycle. x_rd holds its value after done until the next completion to x.
- Reset asserted mid-access:
  - The in-flight access is abandoned: no done pulse, m_req drops on the next edge.
  - The memory must tolerate a dropped request.
  - Requesters re-issue after reset.

Test Plan:
- Core read, c_req=1, c_adr=0x100 at cycle 0; m_ack=1 with m_rd=0xDEADBEEF at cycle 1 -> m_req=1 and m_adr=0x100 in cycle 1; c_done=1 and c_rd=0xDEADBEEF in cycle 2; owner=0; busy 1 only in cycle 1.
- Both masters hold req after reset; memory acks each access immediately -> grant order C,D,C,D across 4 accesses; owner toggles; never both done in the same cycle.
- DMA write with d_we=1, d_adr=0x40, d_wd=0x12345678; d_adr changes to 0x80 one cycle after grant; ack delayed 3 cycles -> m_adr stays 0x40 and m_we=1 throughout; d_done after the ack with d_rd=0.
- MAX_WAIT=4, core read, no ack -> abort after 4 waiting grant cycles; c_done=1 with c_rd=0; timeout_err=1. Next access acked normally and completes, and timeout_err stays 1.
- MAX_WAIT=4, m_ack arrives on the cycle the counter hits 4 -> normal completion, rd equals m_rd, timeout_err=0.
- Reset pulse during GRANT_D with ack pending -> next edge m_req=0, busy=0, owner=1; no d_done; a later m_ack is ignored; a subsequent c_req is served normally.
